// File: rtl/mips_mem_pkg.sv
// Shared types and byte-packing helpers for the main-memory arbiter.
// Bytes are big-endian: b[0] is the most significant byte of a word.
package mips_mem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } mem_port_t;

  typedef logic [0:3][7:0] byte4_t;

  function automatic logic [31:0] pack_word(input byte4_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic byte4_t unpack_word(input logic [31:0] w);
    byte4_t b;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between instruction and data requesters.
// On conflict the side that did not win last time is chosen.
module rr_arbiter2
  import mips_mem_pkg::*;
(
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  always_comb begin
    o_valid = i_ireq | i_dreq;
    o_grant = PORT_I;
    if (i_ireq && i_dreq) begin
      o_grant = (i_last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (i_dreq) begin
      o_grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between instruction fetch and the data cache.
// Each granted access holds the memory port for MEM_LATENCY cycles, then acks.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            i_req,
  input  logic [31:0]     i_addr,
  output logic            i_ack,
  output logic [31:0]     i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [31:0]     d_addr,
  input  logic [31:0]     d_wdata,
  output logic            d_ack,
  output logic [31:0]     d_rdata,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  input  logic [0:3][7:0] mem_data_out,
  output logic            mem_write_en,
  output logic            busy,
  output logic [1:0]      o_dbg_state,
  output logic            o_dbg_last_grant
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  mem_state_t       r_state;
  mem_state_t       w_next_state;
  mem_port_t        r_last_grant;
  mem_port_t        r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [31:0]      r_wdata;
  logic [31:0]      r_i_rdata;
  logic [31:0]      r_d_rdata;
  logic             w_grant_valid;
  logic             w_grant;

  rr_arbiter2 u_rr (
    .i_ireq       (i_req),
    .i_dreq       (d_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_grant_valid),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = BUSY;
      BUSY:    if (r_cnt == '0) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake: a requester holds req until it sees its one-cycle ack; req is
  // only sampled in IDLE, and everything about the access is latched at grant.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= PORT_I;
      r_owner      <= PORT_I;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner <= mem_port_t'(w_grant);
            r_cnt   <= CNT_LOAD;
            if (w_grant == PORT_D) begin
              r_addr  <= d_addr;
              r_we    <= d_we;
              r_wdata <= d_wdata;
            end else begin
              r_addr  <= i_addr;
              r_we    <= 1'b0;
              r_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_last_grant <= r_owner;
            if (!r_we) begin
              if (r_owner == PORT_D) r_d_rdata <= pack_word(mem_data_out);
              else                   r_i_rdata <= pack_word(mem_data_out);
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_ack            = (r_state == DONE) && (r_owner == PORT_I);
  assign d_ack            = (r_state == DONE) && (r_owner == PORT_D);
  assign i_rdata          = r_i_rdata;
  assign d_rdata          = r_d_rdata;
  assign mem_addr         = r_addr;
  assign mem_data_in      = unpack_word(r_wdata);
  assign mem_write_en     = (r_state == BUSY) && r_we;
  assign busy             = (r_state != IDLE);
  assign o_dbg_state      = r_state;
  assign o_dbg_last_grant = r_last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-4 instance plus a latency-1 instance
// sharing a byte-array memory model; acks are checked against an expected queue.
module tb_mem_arbiter;
  import mips_mem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_b = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // latency-4 DUT signals
  logic            i_req = 1'b0;
  logic [31:0]     i_addr = '0;
  logic            i_ack;
  logic [31:0]     i_rdata;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [31:0]     d_addr = '0;
  logic [31:0]     d_wdata = '0;
  logic            d_ack;
  logic [31:0]     d_rdata;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic [0:3][7:0] mem_data_out;
  logic            mem_write_en;
  logic            busy;
  logic [1:0]      dbg_state;
  logic            dbg_last_grant;

  // latency-1 DUT signals
  logic            l1_i_req = 1'b0;
  logic [31:0]     l1_i_addr = '0;
  logic            l1_i_ack;
  logic [31:0]     l1_i_rdata;
  logic            l1_d_req = 1'b0;
  logic            l1_d_we = 1'b0;
  logic [31:0]     l1_d_addr = '0;
  logic [31:0]     l1_d_wdata = '0;
  logic            l1_d_ack;
  logic [31:0]     l1_d_rdata;
  logic [31:0]     l1_mem_addr;
  logic [0:3][7:0] l1_mem_data_in;
  logic [0:3][7:0] l1_mem_data_out;
  logic            l1_mem_write_en;
  logic            l1_busy;
  logic [1:0]      l1_dbg_state;
  logic            l1_dbg_last_grant;

  mem_arbiter #(.MEM_LATENCY(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .busy(busy),
    .o_dbg_state(dbg_state), .o_dbg_last_grant(dbg_last_grant)
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_addr(l1_mem_addr), .mem_data_in(l1_mem_data_in), .mem_data_out(l1_mem_data_out),
    .mem_write_en(l1_mem_write_en), .busy(l1_busy),
    .o_dbg_state(l1_dbg_state), .o_dbg_last_grant(l1_dbg_last_grant)
  );

  // byte-array memory: initial contents mem[a] = a[7:0]
  logic [7:0] mem [0:511];
  logic [8:0] wr_a;
  assign mem_data_out = {mem[mem_addr[8:0]], mem[mem_addr[8:0] + 9'd1],
                         mem[mem_addr[8:0] + 9'd2], mem[mem_addr[8:0] + 9'd3]};
  assign l1_mem_data_out = {mem[l1_mem_addr[8:0]], mem[l1_mem_addr[8:0] + 9'd1],
                            mem[l1_mem_addr[8:0] + 9'd2], mem[l1_mem_addr[8:0] + 9'd3]};

  // scoreboard state
  logic [31:0] exp_i_q[$];
  int          exp_i_cyc_q[$];
  logic [31:0] exp_d_q[$];
  int          exp_d_cyc_q[$];
  logic [31:0] exp_l1_q[$];
  int          exp_l1_cyc_q[$];
  logic [31:0] exp_wdata = '0;
  int          we_cycles = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: ack with no expected access (cycle %0d)", name, cyc);
  endtask

  // monitor: pops expectations whenever an ack appears, checks write traffic
  initial begin
    forever begin
      @(negedge clk);
      if (i_ack) begin
        if (exp_i_q.size() == 0) unexpected("i_ack");
        else begin
          chk("i_rdata", i_rdata, exp_i_q.pop_front());
          chk("i_ack_cycle", cyc, exp_i_cyc_q.pop_front());
        end
      end
      if (d_ack) begin
        if (exp_d_q.size() == 0) unexpected("d_ack");
        else begin
          chk("d_rdata", d_rdata, exp_d_q.pop_front());
          chk("d_ack_cycle", cyc, exp_d_cyc_q.pop_front());
        end
      end
      if (l1_i_ack) begin
        if (exp_l1_q.size() == 0) unexpected("l1_i_ack");
        else begin
          chk("l1_i_rdata", l1_i_rdata, exp_l1_q.pop_front());
          chk("l1_i_ack_cycle", cyc, exp_l1_cyc_q.pop_front());
        end
      end
      if (mem_write_en) begin
        we_cycles++;
        chk("mem_data_in", mem_data_in, exp_wdata);
        wr_a = mem_addr[8:0];
        mem[wr_a]        = mem_data_in[0];
        mem[wr_a + 9'd1] = mem_data_in[1];
        mem[wr_a + 9'd2] = mem_data_in[2];
        mem[wr_a + 9'd3] = mem_data_in[3];
      end
    end
  end

  function automatic logic ack_of(input int which);
    case (which)
      0:       return i_ack;
      1:       return d_ack;
      default: return l1_i_ack;
    endcase
  endfunction

  // bounded wait, returns at the negedge where the ack is visible
  task automatic wait_ack(input int which, input string name);
    int w = 0;
    while (!ack_of(which) && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!ack_of(which)) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within 60 cycles (cycle %0d)", name, cyc);
    end
  endtask

  // driver tasks: raise req now, keep it for n acks, drop it the cycle after the last
  task automatic i_seq(input logic [31:0] a0, input logic [31:0] a1, input int n);
    i_addr = a0;
    i_req  = 1'b1;
    repeat (n) begin
      wait_ack(0, "i_ack_timeout");
      @(negedge clk);
      i_addr = a1;
    end
    i_req = 1'b0;
  endtask

  task automatic d_seq(input logic we, input logic [31:0] a, input logic [31:0] wd, input int n);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    repeat (n) begin
      wait_ack(1, "d_ack_timeout");
      @(negedge clk);
    end
    d_req = 1'b0;
  endtask

  task automatic l1_seq(input logic [31:0] a0, input logic [31:0] a1, input int n);
    l1_i_addr = a0;
    l1_i_req  = 1'b1;
    repeat (n) begin
      wait_ack(2, "l1_ack_timeout");
      @(negedge clk);
      l1_i_addr = a1;
    end
    l1_i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int c;

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 8'(a);
    mem[9'h040] = 8'h12;
    mem[9'h041] = 8'h34;
    mem[9'h042] = 8'h56;
    mem[9'h043] = 8'h78;

    repeat (3) @(negedge clk);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_write_en", mem_write_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_state", dbg_state, IDLE);
    rst_b = 1'b0;
    @(negedge clk);

    // single I read at 0x40: ack 5 cycles after the sampling edge
    we_cycles = 0;
    c = cyc;
    exp_i_q.push_back(32'h12345678);
    exp_i_cyc_q.push_back(c + 5);
    i_seq(32'h40, 32'h40, 1);
    chk("i_read_no_write", we_cycles, 0);

    // D write: four write-enable cycles, d_rdata stays at its reset value
    we_cycles = 0;
    exp_wdata = 32'hDEADBEEF;
    c = cyc;
    exp_d_q.push_back(32'h0);
    exp_d_cyc_q.push_back(c + 5);
    d_seq(1'b1, 32'h100, 32'hDEADBEEF, 1);
    chk("write_en_cycles", we_cycles, 4);

    // D read back of the written word
    c = cyc;
    exp_d_q.push_back(32'hDEADBEEF);
    exp_d_cyc_q.push_back(c + 5);
    d_seq(1'b0, 32'h100, 32'h0, 1);

    // d_addr changes mid-access: memory address must stay at the granted one
    c = cyc;
    exp_d_q.push_back(32'h80818283);
    exp_d_cyc_q.push_back(c + 5);
    fork
      d_seq(1'b0, 32'h80, 32'h0, 1);
      begin
        repeat (2) @(negedge clk);
        d_addr = 32'h1F0;
        repeat (4) begin
          chk("mem_addr_hold", mem_addr, 32'h80);
          @(negedge clk);
        end
      end
    join

    // reset in the second BUSY cycle of a D write
    we_cycles = 0;
    exp_wdata = 32'hCAFEF00D;
    d_we    = 1'b1;
    d_addr  = 32'h180;
    d_wdata = 32'hCAFEF00D;
    d_req   = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    @(negedge clk);
    chk("abort_write_en_before", mem_write_en, 1);
    rst_b = 1'b1;
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    chk("abort_write_en_after", mem_write_en, 0);
    chk("abort_busy_after", busy, 0);
    chk("abort_state", dbg_state, IDLE);
    chk("abort_last_grant", dbg_last_grant, PORT_I);
    chk("abort_d_rdata", d_rdata, 0);
    chk("abort_i_rdata", i_rdata, 0);

    // both sides requesting straight out of reset: D, I, D, I
    c = cyc + 1;
    exp_d_q.push_back(32'h80818283);
    exp_d_cyc_q.push_back(c + 5);
    exp_i_q.push_back(32'h12345678);
    exp_i_cyc_q.push_back(c + 11);
    exp_d_q.push_back(32'h80818283);
    exp_d_cyc_q.push_back(c + 17);
    exp_i_q.push_back(32'h12345678);
    exp_i_cyc_q.push_back(c + 23);
    fork
      i_seq(32'h40, 32'h40, 2);
      d_seq(1'b0, 32'h80, 32'h0, 2);
      begin
        @(negedge clk);
        rst_b = 1'b0;
      end
    join

    // latency 1: back-to-back I reads three cycles apart
    c = cyc;
    exp_l1_q.push_back(32'h00010203);
    exp_l1_cyc_q.push_back(c + 2);
    exp_l1_q.push_back(32'h04050607);
    exp_l1_cyc_q.push_back(c + 5);
    l1_seq(32'h0, 32'h4, 2);

    repeat (8) @(negedge clk);
    chk("pending_i", exp_i_q.size(), 0);
    chk("pending_d", exp_d_q.size(), 0);
    chk("pending_l1", exp_l1_q.size(), 0);
    chk("l1_d_ack_idle", l1_d_ack, 0);
    chk("l1_busy_idle", l1_busy, 0);
    chk("l1_write_en_idle", l1_mem_write_en, 0);
    chk("l1_d_rdata_idle", l1_d_rdata, 0);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-fetch side and the data-cache side of the MIPS core. Each side raises a request with a word address (and write data for the data side); the arbiter grants one side, drives the memory for a fixed `MEM_LATENCY`, returns read data with a one-cycle acknowledge, and alternates priority on conflict. It sits between `pc`/instruction fetch, `cache`, and the byte-array main memory.

## Interface
- `MEM_LATENCY`, default 4: cycles a memory access is held on the memory port; legal range 1–15.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_b` in 1: synchronous, active-high reset; the arbiter is reset while `rst_b`=1.
- `i_req` in 1: instruction-side read request; held until `i_ack`.
- `i_addr` in 32: instruction word address.
- `i_ack` out 1: one-cycle pulse, `i_rdata` valid.
- `i_rdata` out 32: fetched word.
- `d_req` in 1: data-side request; held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data address.
- `d_wdata` in 32: data-side write word.
- `d_ack` out 1: one-cycle pulse, access complete, `d_rdata` valid for reads.
- `d_rdata` out 32: read word.
- `mem_addr` out 32: address to main memory.
- `mem_data_in` out 4×8 (`[7:0] [0:3]`): write bytes to memory.
- `mem_data_out` in 4×8 (`[7:0] [0:3]`): read bytes from memory.
- `mem_write_en` out 1: memory write strobe.
- `busy` out 1: 1 in any state other than IDLE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that side.
  - Both requests: grant the side not granted last. `last_grant` resets to I, so D wins the first conflict after reset.
  - On grant, latch into registers: owner, address, `we` (forced 0 for I), and write word. Load `cnt` = `MEM_LATENCY`-1. Go to BUSY.
- BUSY:
  - `mem_addr`, `mem_write_en` and `mem_data_in` are driven from the latched registers only, never combinationally from requester inputs.
  - Decrement `cnt` each cycle.
  - When `cnt`==0: capture `mem_data_out` into the owner's rdata register (reads only), update `last_grant` to the owner, go to DONE.
- DONE: assert the owner's ack for one cycle, then go to IDLE.
- Byte packing:
  - Word = {b[0], b[1], b[2], b[3]}; b[0] is bits 31:24.
  - Writes: `mem_data_in[0]` = wdata[31:24] … `mem_data_in[3]` = wdata[7:0].
- Outside BUSY: `mem_write_en`=0 and `mem_addr` holds its last value.
- `i_rdata` and `d_rdata` hold their value until the next read for that side completes. Writes do not change `d_rdata`.
- A request dropped before ack is a protocol violation. The access still completes and ack still pulses.
- Requester inputs that change after grant do not affect the access in flight.

## Timing
- Reset values: state IDLE, `cnt` 0, `last_grant` I, all ack 0, `mem_write_en` 0, `busy` 0, `mem_addr` 0, `mem_data_in` all 0, `i_rdata`/`d_rdata` 0.
- Reset mid-access:
  - Next edge returns to IDLE.
  - `mem_write_en` is low from that cycle on.
  - No ack is issued for the aborted access.
- Request first sampled high at edge k: BUSY occupies cycles k+1 … k+`MEM_LATENCY`, ack is high in cycle k+`MEM_LATENCY`+1, and the FSM is back in IDLE at k+`MEM_LATENCY`+2.
- `mem_data_out` is sampled at the edge ending the last BUSY cycle. Memory must present data within `MEM_LATENCY` cycles of the address.
- Requester drops req in the cycle after ack. Its req is ignored during DONE. The minimum issue interval is `MEM_LATENCY`+2 cycles.
- `MEM_LATENCY`=1: one BUSY cycle, ack at k+2.
- Starvation bound: a side waits at most one foreign access, i.e. `MEM_LATENCY`+2 cycles.

## Structure
- Package `mips_mem_pkg`:
  - `mem_state_t` enum {IDLE, BUSY, DONE}.
  - `mem_port_t` enum {PORT_I, PORT_D}.
  - `byte4_t` (`[7:0] [0:3]`).
  - Functions `pack_word`/`unpack_word`.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick from `i_req`, `d_req`, `last_grant`. `last_grant` stays a register in `mem_arbiter`.

## Test plan
- Single I read, latency 4, memory bytes {8'h12,8'h34,8'h56,8'h78} at 0x40 → `i_ack` in cycle 5 after req, `i_rdata`=32'h12345678, `d_ack` never.
- D write of 32'hDEADBEEF to 0x100 → `mem_write_en`=1 for exactly 4 cycles, `mem_data_in`={DE,AD,BE,EF}, then `d_ack` pulse, `d_rdata` unchanged.
- `i_req` and `d_req` both high from reset, each re-raised immediately after its ack → grants D, I, D, I; acks at cycles 5, 11, 17, 23.
- Reset in the 2nd BUSY cycle of a D write → `mem_write_en` low from the next cycle, no `d_ack`, state IDLE, `last_grant` I.
- `MEM_LATENCY`=1, back-to-back I reads at 0x0 then 0x4 → acks 3 cycles apart, correct words returned.
- `d_addr` changed during BUSY → `mem_addr` keeps the granted address until DONE.
